// File: rtl/minicpu_pkg.sv
// Shared definitions for the mini-CPU control path: opcodes, instruction field
// positions, decoded-instruction record and the control FSM state type.
package minicpu_pkg;

  localparam int unsigned INSTR_BITS = 18;
  localparam int unsigned REG_AW     = 4;
  localparam int unsigned DATA_W     = 16;

  localparam logic [2:0] OP_LOAD    = 3'd0;
  localparam logic [2:0] OP_ADD     = 3'd1;
  localparam logic [2:0] OP_ADDI    = 3'd2;
  localparam logic [2:0] OP_SUB     = 3'd3;
  localparam logic [2:0] OP_SUBI    = 3'd4;
  localparam logic [2:0] OP_MUL     = 3'd5;
  localparam logic [2:0] OP_CLEAR   = 3'd6;
  localparam logic [2:0] OP_DISPLAY = 3'd7;

  localparam int unsigned F_OP_LSB   = 15;
  localparam int unsigned F_DEST_LSB = 11;
  localparam int unsigned F_SRC1_LSB = 7;
  localparam int unsigned F_SRC2_LSB = 3;
  localparam int unsigned F_SIGN_BIT = 6;
  localparam int unsigned F_IMM_LSB  = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_READ,
    S_EXEC,
    S_WRITE,
    S_CLR
  } ctrl_state_t;

  // src2 and sign/imm overlap in the word; both views are kept
  typedef struct packed {
    logic [2:0]        op;
    logic [REG_AW-1:0] dest;
    logic [REG_AW-1:0] src1;
    logic [REG_AW-1:0] src2;
    logic              sign;
    logic [5:0]        imm;
  } instr_fields_t;

  function automatic instr_fields_t decode_instr(input logic [INSTR_BITS-1:0] w);
    instr_fields_t f;
    f.op   = w[F_OP_LSB   +: 3];
    f.dest = w[F_DEST_LSB +: REG_AW];
    f.src1 = w[F_SRC1_LSB +: REG_AW];
    f.src2 = w[F_SRC2_LSB +: REG_AW];
    f.sign = w[F_SIGN_BIT];
    f.imm  = w[F_IMM_LSB  +: 6];
    return f;
  endfunction

endpackage

// File: rtl/ctrl_clear_seq.sv
// Register-address sweep for CLEAR: counts 0..NREGS-1 while run is high,
// flags the last address and returns to 0 afterwards.
module ctrl_clear_seq
  import minicpu_pkg::*;
#(
  parameter int unsigned NREGS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic [REG_AW-1:0] cnt,
  output logic              done
);

  assign done = run && (cnt == REG_AW'(NREGS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (run && !done) begin
      cnt <= cnt + REG_AW'(1);
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/module_control_unit.sv
// Control stage ahead of module_alu: fetch operands, drive the ALU, write back,
// plus CLEAR/DISPLAY sequencing. Optional instr_count under CTRL_INSTR_COUNT_EN.
module module_control_unit
  import minicpu_pkg::*;
#(
  parameter int unsigned INSTR_W = 18,
  parameter int unsigned NREGS   = 16,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               instr_ready,
  output logic [3:0]         rd_addr1,
  output logic [3:0]         rd_addr2,
  input  logic [15:0]        rd_data1,
  input  logic [15:0]        rd_data2,
  output logic [2:0]         opcode,
  output logic               sinalImm,
  output logic [5:0]         Imm,
  output logic [15:0]        v1ULA,
  output logic [15:0]        v2ULA,
  input  logic [15:0]        valorGuardarULA,
  output logic               wr_en,
  output logic [3:0]         wr_addr,
  output logic [15:0]        wr_data,
  output logic [15:0]        disp_value,
  output logic               disp_valid
`ifdef CTRL_INSTR_COUNT_EN
  ,
  output logic [15:0]        instr_count
`endif
);

  ctrl_state_t       state;
  ctrl_state_t       state_nxt;
  instr_fields_t     fld;
  logic [7:0]        exec_cnt;
  logic              exec_last;
  logic              disp_fire;
  logic              clr_run;
  logic              clr_done;
  logic [REG_AW-1:0] clr_cnt;

  // EXEC spans the ALU input register plus ALU_LAT result stages
  assign exec_last = (exec_cnt == 8'(ALU_LAT));
  assign disp_fire = (state == S_READ) && (fld.op == OP_DISPLAY);
  assign clr_run   = (state == S_CLR);
  assign rd_addr1  = fld.src1;
  assign rd_addr2  = fld.src2;

  ctrl_clear_seq #(.NREGS(NREGS)) u_clear_seq (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (clr_run),
    .cnt  (clr_cnt),
    .done (clr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (instr_valid) state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_READ;
      S_READ: begin
        if (fld.op == OP_DISPLAY)    state_nxt = S_IDLE;
        else if (fld.op == OP_CLEAR) state_nxt = S_CLR;
        else                         state_nxt = S_EXEC;
      end
      S_EXEC:   if (exec_last) state_nxt = S_WRITE;
      S_WRITE:  state_nxt = S_IDLE;
      S_CLR:    if (clr_done) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state == S_IDLE);
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    case (state)
      S_WRITE: begin
        wr_en   = 1'b1;
        wr_addr = fld.dest;
        wr_data = valorGuardarULA;
      end
      S_CLR: begin
        wr_en   = 1'b1;
        wr_addr = clr_cnt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fld        <= '0;
      exec_cnt   <= '0;
      opcode     <= 3'b000;
      sinalImm   <= 1'b0;
      Imm        <= '0;
      v1ULA      <= '0;
      v2ULA      <= '0;
      disp_valid <= 1'b0;
      disp_value <= '0;
    end else begin
      if (state == S_IDLE && instr_valid) begin
        fld <= decode_instr(instr);
      end
      exec_cnt <= (state == S_EXEC) ? exec_cnt + 8'd1 : '0;
      if (state == S_READ) begin
        opcode   <= fld.op;
        sinalImm <= fld.sign;
        Imm      <= fld.imm;
        v1ULA    <= rd_data1;
        v2ULA    <= rd_data2;
      end
      disp_valid <= disp_fire;
      if (disp_fire) begin
        disp_value <= rd_data1;
      end
    end
  end

`ifdef CTRL_INSTR_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count <= '0;
    end else if ((state == S_WRITE) || (clr_run && clr_done) || disp_fire) begin
      instr_count <= instr_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_module_control_unit.sv
// Bench for module_control_unit: register RAM and ALU stubs, directed vector
// table, hand-written multi-cycle sequences and randomized instructions vs a model.
module tb_module_control_unit;

  localparam logic [2:0] LOAD = 3'd0, ADD = 3'd1, ADDI = 3'd2, SUB = 3'd3;
  localparam logic [2:0] SUBI = 3'd4, MUL = 3'd5, CLEAR = 3'd6, DISP = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [17:0] instr = '0;
  logic        instr_ready;
  logic [3:0]  rd_addr1, rd_addr2;
  logic [15:0] rd_data1, rd_data2;
  logic [2:0]  opcode;
  logic        sinalImm;
  logic [5:0]  Imm;
  logic [15:0] v1ULA, v2ULA, valorGuardarULA;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data, disp_value;
  logic        disp_valid;
`ifdef CTRL_INSTR_COUNT_EN
  logic [15:0] instr_count;
`endif

  always #5 clk = ~clk;

  module_control_unit #(.INSTR_W(18), .NREGS(16), .ALU_LAT(1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_ready    (instr_ready),
    .rd_addr1       (rd_addr1),
    .rd_addr2       (rd_addr2),
    .rd_data1       (rd_data1),
    .rd_data2       (rd_data2),
    .opcode         (opcode),
    .sinalImm       (sinalImm),
    .Imm            (Imm),
    .v1ULA          (v1ULA),
    .v2ULA          (v2ULA),
    .valorGuardarULA(valorGuardarULA),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .disp_value     (disp_value),
    .disp_valid     (disp_valid)
`ifdef CTRL_INSTR_COUNT_EN
    ,
    .instr_count    (instr_count)
`endif
  );

  // ALU semantics: imm is a sign/magnitude offset
  function automatic logic [15:0] alu_ref(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic s,
                                          input logic [5:0] im);
    logic [15:0] mag, iv;
    logic [31:0] p;
    mag = {10'd0, im};
    iv  = s ? (16'd0 - mag) : mag;
    p   = 32'(a) * 32'(b);
    case (op)
      LOAD:    return iv;
      ADD:     return a + b;
      ADDI:    return a + iv;
      SUB:     return a - b;
      SUBI:    return a - iv;
      MUL:     return p[15:0];
      default: return 16'd0;
    endcase
  endfunction

  // Register RAM (1-cycle read) and registered ALU stub
  logic [15:0] ram [16];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_addr = '0;
  logic [15:0] pl_data = '0;
  logic [15:0] alu_q = '0;

  always @(posedge clk) begin
    rd_data1 <= ram[rd_addr1];
    rd_data2 <= ram[rd_addr2];
    if (wr_en) ram[wr_addr] <= wr_data;
    else if (pl_en) ram[pl_addr] <= pl_data;
    alu_q <= alu_ref(opcode, v1ULA, v2ULA, sinalImm, Imm);
  end
  assign valorGuardarULA = alu_q;

  logic [15:0] mreg [16];

  typedef struct {
    int          cyc;
    logic [3:0]  addr;
    logic [15:0] data;
  } wev_t;

  wev_t        wq[$];
  int          dq_cyc[$];
  logic [15:0] dq_val[$];
  logic [15:0] o_v1, o_v2;
  logic [2:0]  o_op;
  logic        o_sign;
  logic [5:0]  o_imm;
  int          rdy_cyc;
  logic        busy_bad, extra;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [3:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
    mreg[a] = d;
  endtask

  function automatic logic [17:0] mk_r(input logic [2:0] op, input logic [3:0] d,
                                      input logic [3:0] s1, input logic [3:0] s2);
    return {op, d, s1, s2, 3'b000};
  endfunction

  function automatic logic [17:0] mk_i(input logic [2:0] op, input logic [3:0] d,
                                      input logic [3:0] s1, input logic sg, input logic [5:0] im);
    return {op, d, s1, sg, im};
  endfunction

  // Issue one instruction; cycle indices count edges after the accept edge
  task automatic run_instr(input logic [17:0] w);
    int   n;
    wev_t ev;
    wq.delete(); dq_cyc.delete(); dq_val.delete();
    busy_bad = 1'b0; extra = 1'b0; rdy_cyc = -1;
    n = 0;
    while (!instr_ready && n < 64) begin @(posedge clk); #1; n++; end
    instr = w; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0; instr = 18'($urandom);
    if (instr_ready) busy_bad = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 2) begin
        o_v1 = v1ULA; o_v2 = v2ULA; o_op = opcode; o_sign = sinalImm; o_imm = Imm;
      end
      if (wr_en) begin ev.cyc = c; ev.addr = wr_addr; ev.data = wr_data; wq.push_back(ev); end
      if (disp_valid) begin dq_cyc.push_back(c); dq_val.push_back(disp_value); end
      if (instr_ready) begin rdy_cyc = c; break; end
    end
    @(posedge clk); #1;
    if (wr_en || disp_valid) extra = 1'b1;
  endtask

  task automatic check_obs(input string tag, input logic [17:0] w);
    logic [2:0]  op;
    logic [3:0]  d, s1, s2;
    logic [15:0] exp_wd;
    logic        ok;
    op = w[17:15]; d = w[14:11]; s1 = w[10:7]; s2 = w[6:3];
    exp_wd = alu_ref(op, mreg[s1], mreg[s2], w[6], w[5:0]);
    chk({tag, "_v1ULA"}, o_v1, mreg[s1]);
    chk({tag, "_v2ULA"}, o_v2, mreg[s2]);
    chk({tag, "_opcode"}, o_op, op);
    chk({tag, "_sinalImm"}, o_sign, w[6]);
    chk({tag, "_Imm"}, o_imm, w[5:0]);
    chk({tag, "_ready_low_after_accept"}, busy_bad, 0);
    chk({tag, "_no_trailing_activity"}, extra, 0);
    if (op == DISP) begin
      chk({tag, "_disp_pulses"}, dq_cyc.size(), 1);
      if (dq_cyc.size() == 1) begin
        chk({tag, "_disp_cycle"}, dq_cyc[0], 2);
        chk({tag, "_disp_value"}, dq_val[0], mreg[s1]);
      end
      chk({tag, "_disp_no_write"}, wq.size(), 0);
      chk({tag, "_ready_return"}, rdy_cyc, 2);
    end else if (op == CLEAR) begin
      chk({tag, "_clear_writes"}, wq.size(), 16);
      ok = 1'b1;
      foreach (wq[i]) if (wq[i].cyc != 2 + i || wq[i].addr != 4'(i) || wq[i].data != 16'd0) ok = 1'b0;
      chk({tag, "_clear_sequence"}, ok, 1);
      chk({tag, "_ready_return"}, rdy_cyc, 18);
      chk({tag, "_no_disp"}, dq_cyc.size(), 0);
      for (int i = 0; i < 16; i++) mreg[i] = 16'd0;
    end else begin
      chk({tag, "_writes"}, wq.size(), 1);
      if (wq.size() == 1) begin
        chk({tag, "_wr_cycle"}, wq[0].cyc, 4);
        chk({tag, "_wr_addr"}, wq[0].addr, d);
        chk({tag, "_wr_data"}, wq[0].data, exp_wd);
      end
      chk({tag, "_ready_return"}, rdy_cyc, 5);
      chk({tag, "_no_disp"}, dq_cyc.size(), 0);
      mreg[d] = exp_wd;
    end
  endtask

  typedef struct {
    string       name;
    logic [17:0] w;
    logic [15:0] e_v1, e_v2;
    logic        e_sign;
    logic [5:0]  e_imm;
    logic        e_wr;
    logic [3:0]  e_addr;
    logic [15:0] e_data;
    logic        e_disp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc[$];
    logic        r;
    logic [2:0]  rop;
    logic [17:0] w;
    wev_t        ev;

    // Preload R1=5, R2=7, R4=0xAB; expected values worked out by hand
    vecs[0] = '{"add",     mk_r(ADD, 4'd3, 4'd1, 4'd2),      16'd5,  16'd7, 1'b0, 6'd16, 1'b1, 4'd3, 16'd12, 1'b0};
    vecs[1] = '{"load",    mk_i(LOAD, 4'd1, 4'd0, 1'b0, 6'd10), 16'd0, 16'd5, 1'b0, 6'd10, 1'b1, 4'd1, 16'd10, 1'b0};
    vecs[2] = '{"addi",    mk_i(ADDI, 4'd6, 4'd1, 1'b1, 6'd3), 16'd10, 16'd0, 1'b1, 6'd3, 1'b1, 4'd6, 16'd7, 1'b0};
    vecs[3] = '{"display", mk_r(DISP, 4'd0, 4'd4, 4'd0),     16'hAB, 16'd0, 1'b0, 6'd0, 1'b0, 4'd0, 16'hAB, 1'b1};
    vecs[4] = '{"sub",     mk_r(SUB, 4'd2, 4'd3, 4'd6),      16'd12, 16'd7, 1'b0, 6'd48, 1'b1, 4'd2, 16'd5, 1'b0};
    vecs[5] = '{"mul",     mk_r(MUL, 4'd7, 4'd2, 4'd3),      16'd5, 16'd12, 1'b0, 6'd24, 1'b1, 4'd7, 16'd60, 1'b0};

    for (int i = 0; i < 16; i++) preload(4'(i), 16'd0);

    chk("reset_instr_ready", instr_ready, 1);
    chk("reset_wr_en", wr_en, 0);
    chk("reset_opcode", opcode, 0);
    chk("reset_v1ULA", v1ULA, 0);
    chk("reset_disp_valid", disp_valid, 0);
    chk("reset_wr_addr_data", {wr_addr, wr_data}, 0);

    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    preload(4'd1, 16'd5);
    preload(4'd2, 16'd7);
    preload(4'd4, 16'h00AB);

    for (int i = 0; i < 6; i++) begin
      run_instr(vecs[i].w);
      chk({vecs[i].name, "_v1ULA"}, o_v1, vecs[i].e_v1);
      chk({vecs[i].name, "_v2ULA"}, o_v2, vecs[i].e_v2);
      chk({vecs[i].name, "_opcode"}, o_op, vecs[i].w[17:15]);
      chk({vecs[i].name, "_sinalImm"}, o_sign, vecs[i].e_sign);
      chk({vecs[i].name, "_Imm"}, o_imm, vecs[i].e_imm);
      chk({vecs[i].name, "_write_count"}, wq.size(), vecs[i].e_wr ? 1 : 0);
      if (vecs[i].e_wr && wq.size() == 1) begin
        chk({vecs[i].name, "_wr_cycle"}, wq[0].cyc, 4);
        chk({vecs[i].name, "_wr_addr"}, wq[0].addr, vecs[i].e_addr);
        chk({vecs[i].name, "_wr_data"}, wq[0].data, vecs[i].e_data);
        mreg[vecs[i].e_addr] = vecs[i].e_data;
      end
      chk({vecs[i].name, "_disp_count"}, dq_cyc.size(), vecs[i].e_disp ? 1 : 0);
      if (vecs[i].e_disp && dq_cyc.size() == 1)
        chk({vecs[i].name, "_disp_value"}, dq_val[0], vecs[i].e_data);
      chk({vecs[i].name, "_ready_return"}, rdy_cyc, vecs[i].e_disp ? 2 : 5);
      chk({vecs[i].name, "_trailing"}, extra, 0);
    end

    w = mk_r(CLEAR, 4'd0, 4'd0, 4'd0);
    run_instr(w);
    check_obs("clear", w);

    // Back-to-back with instr_valid held high; B depends on A's result
    preload(4'd1, 16'd3);
    preload(4'd2, 16'd4);
    wq.delete();
    instr = mk_r(ADD, 4'd9, 4'd1, 4'd2);
    instr_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      r = instr_ready;
      @(posedge clk); #1;
      if (r && instr_valid) begin
        acc.push_back(c);
        if (acc.size() == 1) instr = mk_r(ADD, 4'd10, 4'd9, 4'd1);
        else instr_valid = 1'b0;
      end
      if (wr_en) begin ev.cyc = c; ev.addr = wr_addr; ev.data = wr_data; wq.push_back(ev); end
    end
    instr_valid = 1'b0;
    chk("b2b_accepts", acc.size(), 2);
    if (acc.size() == 2) chk("b2b_second_accept_cycle", acc[1], 6);
    chk("b2b_write_count", wq.size(), 2);
    if (wq.size() == 2) begin
      chk("b2b_first_write", {wq[0].cyc[7:0], 4'd0, wq[0].addr, wq[0].data}, {8'd4, 4'd0, 4'd9, 16'd7});
      chk("b2b_second_write", {wq[1].cyc[7:0], 4'd0, wq[1].addr, wq[1].data}, {8'd10, 4'd0, 4'd10, 16'd10});
    end
    mreg[9] = 16'd7;
    mreg[10] = 16'd10;

    // Reset during EXEC
    instr = mk_r(ADD, 4'd11, 4'd1, 4'd2); instr_valid = 1'b1;
    @(posedge clk); #1; instr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3; rst_n = 1'b0; #1;
    chk("rst_exec_instr_ready", instr_ready, 1);
    chk("rst_exec_wr_en", wr_en, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset during WRITE: strobe must drop before the edge, so R12 stays 0
    instr = mk_r(ADD, 4'd12, 4'd1, 4'd2); instr_valid = 1'b1;
    @(posedge clk); #1; instr_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_write_wr_en_before", wr_en, 1);
    #2; rst_n = 1'b0; #1;
    chk("rst_write_wr_en", wr_en, 0);
    chk("rst_write_instr_ready", instr_ready, 1);
    chk("rst_write_outputs", {opcode, v1ULA}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    w = mk_r(ADD, 4'd13, 4'd12, 4'd1);
    run_instr(w);
    check_obs("post_reset", w);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      if (rop == CLEAR && $urandom_range(0, 3) != 0) rop = LOAD;
      w = {rop, 15'($urandom)};
      run_instr(w);
      check_obs($sformatf("rand%0d", i), w);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
